// File: rtl/demux_scan_ctrl_pkg.sv
// scan_pkg: shared definitions for the demux scan controller.
//   CH_NUM  - number of demux destinations.
//   SEL_W   - width of the demux select bus.
//   state_t - controller state encoding.
//             BLANK is reachable only in builds with SCAN_BLANK_EN defined.
package scan_pkg;

  localparam int unsigned CH_NUM = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// demux_scan_ctrl_if: control and demux-facing signals of the scan controller.
//   run        - level; 1 permits scanning.
//   mask       - per-channel participation mask.
//   select     - demux channel select.
//   enable     - demux enable.
//   slot_start - 1-cycle pulse on the first enabled cycle of a slot.
//   frame_done - 1-cycle pulse on the last enabled cycle of the final slot of a frame.
// Modports:
//   master - the controller side; consumes run/mask and drives the demux strobes.
//   slave  - the config/datapath side.
interface demux_scan_ctrl_if
  import scan_pkg::*;
  ();

  logic              run;
  logic [CH_NUM-1:0] mask;
  logic [SEL_W-1:0]  select;
  logic              enable;
  logic              slot_start;
  logic              frame_done;

  modport master (
    input  run, mask,
    output select, enable, slot_start, frame_done
  );

  modport slave (
    output run, mask,
    input  select, enable, slot_start, frame_done
  );

endinterface

// File: rtl/demux_scan_ctrl_rr_next_sel.sv
// rr_next_sel: combinational round-robin successor search.
//   cur  - current channel index.
//   mask - channel participation mask.
//   next - first set mask bit strictly after cur, searching upward with wrap 7->0.
//          If only cur itself is set, next = cur.
//   wrap - next <= cur (the search wrapped). Forced low when mask is empty.
//   none - mask is empty.
module rr_next_sel
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur,
  input  logic [CH_NUM-1:0] mask,
  output logic [SEL_W-1:0]  next,
  output logic              wrap,
  output logic              none
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Offsets 1..CH_NUM. The final offset lands back on cur, so a
  // single-channel mask selects itself.
  always_comb begin
    next  = cur;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
    none = (mask == '0);
    wrap = !none && (next <= cur);
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl: round-robin scan scheduler for a 1x8 demultiplexer.
//   clk     - system clock, rising edge.
//   reset_n - asynchronous active-low reset.
//   bus     - demux_scan_ctrl_if.master (run, mask in; select, enable,
//             slot_start, frame_done out; all outputs registered).
// Parameters:
//   PRESCALE     - dwell cycles per slot (2..65535).
//   BLANK_CYCLES - guard cycles between slots (1..255).
// Build option:
//   SCAN_BLANK_EN - inserts BLANK_CYCLES cycles with enable low between slots.
//                   When undefined, slots run back to back and BLANK_CYCLES is unused.
module demux_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned BLANK_CYCLES = 1
)(
  input  logic              clk,
  input  logic              reset_n,
  demux_scan_ctrl_if.master bus
);

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("PRESCALE out of range 2..65535");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > 255) begin : g_bad_blank
    $error("BLANK_CYCLES out of range 1..255");
  end

  localparam logic [15:0] CNT_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] CNT_PRE  = 16'(PRESCALE - 2);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              en_q, en_d;
  logic              ss_q, ss_d;
  logic              fd_q, fd_d;
  logic [SEL_W-1:0]  nxt_q, nxt_d;
  logic              none_q, none_d;

  logic [SEL_W-1:0]  rr_cur;
  logic [SEL_W-1:0]  rr_next;
  logic              rr_wrap;
  logic              rr_none;

`ifdef SCAN_BLANK_EN
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
  logic [7:0] bcnt_q, bcnt_d;
`endif

  // In IDLE, searching from 7 yields the lowest set bit.
  assign rr_cur = (state_q == IDLE) ? '1 : sel_q;

  rr_next_sel u_rr_next_sel (
    .cur  (rr_cur),
    .mask (bus.mask),
    .next (rr_next),
    .wrap (rr_wrap),
    .none (rr_none)
  );

  // The mask is captured on the edge that begins the last dwell cycle.
  // This lets frame_done, which is registered, be high during that same cycle.
  // The captured successor is then applied at the slot boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    ss_d    = 1'b0;
    fd_d    = 1'b0;
    nxt_d   = nxt_q;
    none_d  = none_q;
`ifdef SCAN_BLANK_EN
    bcnt_d  = bcnt_q;
`endif
    case (state_q)
      IDLE: begin
        en_d  = 1'b0;
        cnt_d = '0;
        if (bus.run && !rr_none) begin
          state_d = ACTIVE;
          sel_d   = rr_next;
          en_d    = 1'b1;
          ss_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!bus.run) begin
          state_d = IDLE;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == CNT_PRE) begin
            nxt_d  = rr_next;
            none_d = rr_none;
            fd_d   = rr_wrap;
          end
        end else begin
          cnt_d = '0;
          if (none_q) begin
            state_d = IDLE;
            en_d    = 1'b0;
          end else begin
`ifdef SCAN_BLANK_EN
            state_d = BLANK;
            en_d    = 1'b0;
            bcnt_d  = '0;
`else
            sel_d   = nxt_q;
            ss_d    = 1'b1;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      BLANK: begin
        if (!bus.run) begin
          state_d = IDLE;
          en_d    = 1'b0;
        end else if (bcnt_q == BLANK_LAST) begin
          state_d = ACTIVE;
          sel_d   = nxt_q;
          en_d    = 1'b1;
          ss_d    = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      ss_q    <= 1'b0;
      fd_q    <= 1'b0;
      nxt_q   <= '0;
      none_q  <= 1'b0;
`ifdef SCAN_BLANK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ss_q    <= ss_d;
      fd_q    <= fd_d;
      nxt_q   <= nxt_d;
      none_q  <= none_d;
`ifdef SCAN_BLANK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign bus.select     = sel_q;
  assign bus.enable     = en_q;
  assign bus.slot_start = ss_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl: scoreboard bench for demux_scan_ctrl (PRESCALE=4, BLANK_CYCLES=1).
// With SCAN_BLANK_EN defined, the blanking pattern is exercised instead of
// the back-to-back sequence.
module tb_demux_scan_ctrl;

  logic clk;
  logic reset_n;

  demux_scan_ctrl_if bus ();

  demux_scan_ctrl #(
    .PRESCALE     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected per-cycle outputs packed as {enable, select[2:0], slot_start, frame_done}.
  string      exp_n[$];
  logic [5:0] exp_v[$];
  int         errors = 0;
  int         checks = 0;

  string      mon_n;
  logic [5:0] mon_e;
  logic [5:0] mon_a;

  always @(negedge clk) begin
    if (exp_v.size() > 0) begin
      mon_n = exp_n.pop_front();
      mon_e = exp_v.pop_front();
      mon_a = {bus.enable, bus.select, bus.slot_start, bus.frame_done};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got en/sel/ss/fd=%b_%b_%b_%b expected %b_%b_%b_%b",
                 mon_n, mon_a[5], mon_a[4:2], mon_a[1], mon_a[0],
                 mon_e[5], mon_e[4:2], mon_e[1], mon_e[0]);
      end
    end
  end

  // Record what the outputs must show in the current cycle, then drive the
  // inputs that the next rising edge samples.
  task automatic step(input string nm, input logic e, input logic [2:0] s,
                      input logic ss, input logic fd, input logic r,
                      input logic [7:0] m);
    @(posedge clk);
    #1;
    exp_n.push_back(nm);
    exp_v.push_back({e, s, ss, fd});
    bus.run  = r;
    bus.mask = m;
  endtask

  task automatic slot(input string nm, input logic [2:0] s, input logic fd,
                      input logic r, input logic [7:0] m);
    step($sformatf("%s_ch%0d_c0", nm, s), 1'b1, s, 1'b1, 1'b0, r, m);
    step($sformatf("%s_ch%0d_c1", nm, s), 1'b1, s, 1'b0, 1'b0, r, m);
    step($sformatf("%s_ch%0d_c2", nm, s), 1'b1, s, 1'b0, 1'b0, r, m);
    step($sformatf("%s_ch%0d_c3", nm, s), 1'b1, s, 1'b0, fd,   r, m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    bus.run  = 1'b0;
    bus.mask = 8'h00;
    #22 reset_n = 1'b1;
  end

  initial begin
`ifdef SCAN_BLANK_EN
    step("rst0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("rst1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h03);
    slot("blk", 3'd0, 1'b0, 1'b1, 8'h03);
    step("blank0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h03);
    slot("blk", 3'd1, 1'b1, 1'b1, 8'h03);
    step("blank1", 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h03);
    step("blk_wrap_c0", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'h03);
    step("blk_stop", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h03);
`else
    // Reset state, then run with all channels.
    step("rst0", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    step("rst1", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFF);
    for (int ch = 0; ch < 8; ch++)
      slot("ff", 3'(ch), (ch == 7), 1'b1, 8'hFF);
    // Wrap to channel 0; the mask switches to 1010_0100 inside this slot.
    slot("ffwrap", 3'd0, 1'b0, 1'b1, 8'hA4);
    slot("a4", 3'd2, 1'b0, 1'b1, 8'hA4);
    slot("a4", 3'd5, 1'b0, 1'b1, 8'hA4);
    slot("a4", 3'd7, 1'b1, 1'b1, 8'hA4);
    // Channel 2 again; the mask changes to the single channel 4.
    slot("a4wrap", 3'd2, 1'b0, 1'b1, 8'h10);
    slot("single", 3'd4, 1'b1, 1'b1, 8'h10);
    slot("single", 3'd4, 1'b1, 1'b1, 8'h0F);
    slot("f", 3'd0, 1'b0, 1'b1, 8'h0F);
    slot("f", 3'd1, 1'b0, 1'b1, 8'h0F);
    slot("f", 3'd2, 1'b0, 1'b1, 8'h0F);
    // Clearing bit 3 mid-slot keeps the full dwell; successor wraps to 0.
    step("clr3_c0", 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h07);
    step("clr3_c1", 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h07);
    step("clr3_c2", 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h07);
    step("clr3_c3", 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 8'h07);
    slot("m7", 3'd0, 1'b0, 1'b1, 8'h07);
    // Mask empty at the boundary: full slot, no frame_done, then idle.
    slot("m0", 3'd1, 1'b0, 1'b1, 8'h00);
    step("idle_m0", 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 8'h0C);
    // Run drops in the second cycle of a slot.
    step("drop_c0", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 8'h0C);
    step("drop_c1", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h0C);
    step("aborted", 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h30);
    slot("restart", 3'd4, 1'b0, 1'b1, 8'h30);
    slot("restart", 3'd5, 1'b1, 1'b1, 8'h30);
    step("pre_arst_c0", 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 8'h30);
    // Reset pulse that starts and ends between two rising edges.
    fork
      step("arst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h30);
      begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        #6 reset_n = 1'b1;
      end
    join
    slot("post_arst", 3'd4, 1'b0, 1'b1, 8'h30);
    step("stop_c0", 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 8'h30);
    step("stopped", 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'h30);
    step("stopped2", 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'h30);
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (exp_v.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, required 0", exp_v.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
